// File: rtl/audioport_pkg.sv
// Shared audio-port definitions.
// Holds the I2S frame geometry, the stereo sample container, the I2S
// transmitter state type and a helper that lays a stereo sample out as one
// 64-bit I2S frame (MSB first, left word then right word, zero padded).
package audioport_pkg;

    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int AUDIO_BITS     = 24;
    localparam int I2S_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [AUDIO_BITS-1:0] right;
        logic [AUDIO_BITS-1:0] left;
    } stereo_sample_t;

    typedef enum logic {
        I2S_IDLE,
        I2S_RUN
    } i2s_state_t;

    // Frame image shifted out from bit 63 downward: left word, pad, right word, pad.
    function automatic logic [I2S_FRAME_BITS-1:0] i2s_frame(stereo_sample_t s);
        return {s.left,  {(I2S_SLOT_BITS-AUDIO_BITS){1'b0}},
                s.right, {(I2S_SLOT_BITS-AUDIO_BITS){1'b0}}};
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Small synchronous FIFO of stereo samples feeding the I2S serialiser.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   flush        empties the FIFO (same effect as reset on the pointers)
//   push         write push_data; accepted when not full, or when full but
//                a pop happens in the same cycle
//   push_data    stereo sample to store
//   pop          remove head; ignored when empty (an empty pop does not
//                see a same-cycle push)
//   head         current head entry, valid while empty=0
//   full, empty  occupancy flags
module i2s_sample_fifo
    import audioport_pkg::*;
#(
    parameter int DEPTH = I2S_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  stereo_sample_t push_data,
    input  logic           pop,
    output stereo_sample_t head,
    output logic           full,
    output logic           empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    stereo_sample_t  mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_tx_unit.sv
// Philips I2S transmitter: buffers stereo samples from dsp_unit in a
// 2-entry FIFO and serialises them as sck/ws/sdo toward the external DAC.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   play_in         1 = stream, 0 = stop and flush
//   tick_in         1-cycle strobe qualifying audio0_in/audio1_in
//   audio0_in       left sample (24-bit two's complement)
//   audio1_in       right sample (24-bit two's complement)
//   sck_out         serial bit clock (low for the first SCK_HALF clk of a slot)
//   ws_out          word select, 0 = left, 1 = right
//   sdo_out         serial data, MSB first
//   underflow_out   1-clk pulse: a frame started with the FIFO empty
//   overflow_out    1-clk pulse: a tick was dropped because the FIFO was full
// Build option: define I2S_REPEAT_ON_UNDERFLOW_EN to replay the last popped
// sample on underflow instead of sending a silent (all-zero) frame.
//
// state    | meaning
// ---------+----------------------------------------------------------
// I2S_IDLE | outputs 0, FIFO held empty while play_in=0
// I2S_RUN  | streaming frames; play_in=0 returns to IDLE next cycle
module i2s_tx_unit
    import audioport_pkg::*;
#(
    parameter int SCK_HALF   = 2,
    parameter int FIFO_DEPTH = I2S_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_in,
    input  logic        tick_in,
    input  logic [23:0] audio0_in,
    input  logic [23:0] audio1_in,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sdo_out,
    output logic        underflow_out,
    output logic        overflow_out
);

    localparam int PW = $clog2(2 * SCK_HALF);
    localparam int BW = $clog2(I2S_FRAME_BITS);
    localparam logic [PW-1:0] PH_MAX   = PW'(2 * SCK_HALF - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(SCK_HALF);
    localparam logic [BW-1:0] BIT_LAST = BW'(I2S_FRAME_BITS - 1);
    localparam logic [BW-1:0] WS_RISE  = BW'(I2S_SLOT_BITS - 1);
    localparam logic [BW-1:0] WS_FALL  = BW'(I2S_FRAME_BITS - 2);

    i2s_state_t                state;
    i2s_state_t                state_next;
    logic [PW-1:0]             ph_cnt;
    logic [BW-1:0]             bit_idx;
    logic [I2S_FRAME_BITS-1:0] sreg;
    logic [I2S_FRAME_BITS-1:0] fill_frame;
    logic                      load;
    logic                      flush;
    logic                      push;
    logic                      slot_end;
    logic                      running;
    logic                      underflow_q;
    logic                      overflow_q;
    stereo_sample_t            head;
    stereo_sample_t            push_data;
    logic                      full;
    logic                      empty;

    // Phase timer counts down; the slot ends when it reaches zero.
    assign slot_end  = (ph_cnt == '0);
    assign running   = (state == I2S_RUN);
    assign push      = tick_in && play_in;
    assign push_data = '{right: audio1_in, left: audio0_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= I2S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        flush      = 1'b0;
        case (state)
            I2S_IDLE: begin
                flush = !play_in;
                if (play_in) begin
                    state_next = I2S_RUN;
                    load       = 1'b1;
                end
            end
            I2S_RUN: begin
                if (!play_in) begin
                    state_next = I2S_IDLE;
                    flush      = 1'b1;
                end else if (slot_end && bit_idx == BIT_LAST) begin
                    load = 1'b1;
                end
            end
            default: state_next = I2S_IDLE;
        endcase
    end

    i2s_sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (load),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

`ifdef I2S_REPEAT_ON_UNDERFLOW_EN
    stereo_sample_t last_sample;

    always_ff @(posedge clk) begin
        if (rst || !play_in) begin
            last_sample <= '0;
        end else if (load && !empty) begin
            last_sample <= head;
        end
    end

    assign fill_frame = i2s_frame(last_sample);
`else
    assign fill_frame = '0;
`endif

    // Loading presets the timer so the first RUN cycle is b=0, phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cnt  <= '0;
            bit_idx <= '0;
            sreg    <= '0;
        end else if (load) begin
            ph_cnt  <= PH_MAX;
            bit_idx <= '0;
            sreg    <= empty ? fill_frame : i2s_frame(head);
        end else if (running && play_in) begin
            if (slot_end) begin
                ph_cnt  <= PH_MAX;
                bit_idx <= bit_idx + 1'b1;
                sreg    <= {sreg[I2S_FRAME_BITS-2:0], 1'b0};
            end else begin
                ph_cnt  <= ph_cnt - 1'b1;
            end
        end else begin
            ph_cnt  <= '0;
            bit_idx <= '0;
            sreg    <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            underflow_q <= load && empty;
            overflow_q  <= push && full && !load;
        end
    end

    // Down-count value below SCK_HALF means phase >= SCK_HALF: sck high.
    assign sck_out       = running && (ph_cnt < PH_HALF);
    assign ws_out        = running && (bit_idx >= WS_RISE) && (bit_idx <= WS_FALL);
    assign sdo_out       = running && sreg[I2S_FRAME_BITS-1];
    assign underflow_out = underflow_q;
    assign overflow_out  = overflow_q;

endmodule

// File: tb/tb_i2s_tx_unit.sv
module tb_i2s_tx_unit;

    localparam int H         = 2;
    localparam int SLOT_CLK  = 2 * H;
    localparam int FRAME_CLK = 64 * SLOT_CLK;

    logic        clk = 1'b0;
    logic        rst;
    logic        play_in;
    logic        tick_in;
    logic [23:0] audio0_in;
    logic [23:0] audio1_in;
    logic        sck_out;
    logic        ws_out;
    logic        sdo_out;
    logic        underflow_out;
    logic        overflow_out;

    i2s_tx_unit #(.SCK_HALF(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .play_in       (play_in),
        .tick_in       (tick_in),
        .audio0_in     (audio0_in),
        .audio1_in     (audio1_in),
        .sck_out       (sck_out),
        .ws_out        (ws_out),
        .sdo_out       (sdo_out),
        .underflow_out (underflow_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {right,left}, clock count since frame start,
    // the sample on air and the event pulses.
    logic [47:0] q[$];
    int          m_t    = 0;
    bit          m_play = 1'b0;
    logic [23:0] m_l    = '0;
    logic [23:0] m_r    = '0;
    logic        m_uf   = 1'b0;
    logic        m_of   = 1'b0;
`ifdef I2S_REPEAT_ON_UNDERFLOW_EN
    logic [47:0] m_last = '0;
`endif

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t frame_clk=%0d: observed=%0b expected=%0b",
                   tag, $time, m_t, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [47:0] s;
        if (rst || !play_in) begin
            m_play = 1'b0;
            q.delete();
            m_uf = 1'b0;
            m_of = 1'b0;
            m_t  = 0;
            m_l  = '0;
            m_r  = '0;
`ifdef I2S_REPEAT_ON_UNDERFLOW_EN
            m_last = '0;
`endif
        end else begin
            m_uf = 1'b0;
            m_of = 1'b0;
            if (!m_play || m_t == FRAME_CLK - 1) begin
                if (q.size() > 0) begin
                    s   = q.pop_front();
                    m_l = s[23:0];
                    m_r = s[47:24];
`ifdef I2S_REPEAT_ON_UNDERFLOW_EN
                    m_last = s;
`endif
                end else begin
                    m_uf = 1'b1;
`ifdef I2S_REPEAT_ON_UNDERFLOW_EN
                    m_l = m_last[23:0];
                    m_r = m_last[47:24];
`else
                    m_l = '0;
                    m_r = '0;
`endif
                end
                m_t    = 0;
                m_play = 1'b1;
            end else begin
                m_t++;
            end
            // Pop happens first, so a full FIFO that is popped accepts the push
            // and an empty FIFO that is popped only stores it for later.
            if (tick_in) begin
                if (q.size() < 2) q.push_back({audio1_in, audio0_in});
                else              m_of = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int          b;
        int          ph;
        logic [23:0] v;
        logic        e_sck;
        logic        e_ws;
        logic        e_sdo;
        b     = m_t / SLOT_CLK;
        ph    = m_t % SLOT_CLK;
        e_sck = m_play && (ph >= H);
        e_ws  = m_play && (b >= 31) && (b <= 62);
        e_sdo = 1'b0;
        if (m_play) begin
            if (b < 24) begin
                v = m_l << b;
                e_sdo = v[23];
            end else if (b >= 32 && b < 56) begin
                v = m_r << (b - 32);
                e_sdo = v[23];
            end
        end
        chk("sck_out", sck_out, e_sck);
        chk("ws_out", ws_out, e_ws);
        chk("sdo_out", sdo_out, e_sdo);
        chk("underflow_out", underflow_out, m_uf);
        chk("overflow_out", overflow_out, m_of);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        while (m_t != target && n < 2 * FRAME_CLK) begin
            cycle();
            n++;
        end
        checks++;
        assert (m_t == target) else begin
            errors++;
            $error("FAIL wait_t: observed frame_clk=%0d expected %0d", m_t, target);
        end
    endtask

    task automatic tick_once(input logic [23:0] l, input logic [23:0] r);
        tick_in   = 1'b1;
        audio0_in = l;
        audio1_in = r;
        cycle();
        tick_in   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        play_in   = 1'b1;
        tick_in   = 1'b0;
        audio0_in = '0;
        audio1_in = '0;

        // Reset held with play and ticks active: everything stays 0.
        for (int i = 0; i < 6; i++) begin
            tick_in   = (i % 2 == 0);
            audio0_in = 24'($urandom);
            audio1_in = 24'($urandom);
            cycle();
        end
        tick_in = 1'b0;
        rst     = 1'b0;
        cycles(300);

        // Known pattern; the tick lands on the start cycle so it plays in frame 2.
        play_in = 1'b0;
        cycles(3);
        play_in = 1'b1;
        tick_once(24'hA5A5A5, 24'h5A5A5A);
        cycles(2 * FRAME_CLK);

        // Empty FIFO: underflow every frame, then one sample followed by silence/repeat.
        play_in = 1'b0;
        cycles(3);
        play_in = 1'b1;
        cycles(2 * FRAME_CLK);
        wait_t(77);
        tick_once(24'h800001, 24'h7FFFFF);
        cycles(3 * FRAME_CLK);

        // Ticks ignored while stopped, then a third tick overflows a 2-entry FIFO.
        play_in = 1'b0;
        for (int i = 0; i < 3; i++) tick_once(24'($urandom), 24'($urandom));
        play_in = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) tick_once(24'($urandom), 24'($urandom));
        cycles(3 * FRAME_CLK);

        // Tick exactly on the frame-load cycle with the FIFO full.
        wait_t(10);
        tick_once(24'($urandom), 24'($urandom));
        tick_once(24'($urandom), 24'($urandom));
        wait_t(FRAME_CLK - 1);
        tick_once(24'($urandom), 24'($urandom));
        cycles(3 * FRAME_CLK + 10);

        // Stop at b=40 with a queued sample; restart must underflow with zeros.
        tick_once(24'($urandom), 24'($urandom));
        wait_t(40 * SLOT_CLK);
        play_in = 1'b0;
        cycle();
        cycles(3);
        play_in = 1'b1;
        cycles(FRAME_CLK + 5);

        // Random traffic with occasional stops and resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 499) == 0) play_in = ~play_in;
            else if (!play_in && $urandom_range(0, 19) == 0) play_in = 1'b1;
            tick_in   = ($urandom_range(0, 99) < 2);
            audio0_in = 24'($urandom);
            audio1_in = 24'($urandom);
            cycle();
        end
        rst     = 1'b0;
        tick_in = 1'b0;
        cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
